// File: rtl/joy_pot_slew.sv
// joy_pot_slew: maps two joysticks to four slew-limited 8-bit pot voltages (ch1..ch4).
// Optional feature: define JOY_CENTER_DEADZONE_EN for a centre dead band on analog input.
module joy_pot_slew #(
  parameter int TICK_DIV = 1024,
  parameter int STEP     = 4,
  parameter int DEADZONE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        analog,
  input  logic [15:0] joy_a1,
  input  logic [15:0] joy_a2,
  input  logic [3:0]  dj1,
  input  logic [3:0]  dj2,
  output logic [7:0]  ch1,
  output logic [7:0]  ch2,
  output logic [7:0]  ch3,
  output logic [7:0]  ch4,
  output logic        upd
);

  localparam int              CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]      STEP_V    = 8'(STEP);
  localparam logic [7:0]      CENTER    = 8'd128;

  // Out-of-range parameters would break the one-pass-per-tick timing or the 8-bit step.
  if (TICK_DIV < 8 || STEP < 1 || STEP > 255 || DEADZONE < 0 || DEADZONE > 127) begin : g_param_check
    $error("joy_pot_slew: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          upd_q, upd_d;
  logic [7:0]    ch_q [4];
  logic [7:0]    ch_d [4];

  logic          tick_s;
  logic [7:0]    tgt_s [4];
  logic          sel_en_s;
  logic [1:0]    sel_idx_s;
  logic [7:0]    sel_cur_s;
  logic [7:0]    sel_tgt_s;
  logic          up_s;
  logic [7:0]    diff_s;
  logic [7:0]    step_s;
  logic [7:0]    slewed_s;

  function automatic logic [7:0] analog_target(input logic [7:0] raw);
    logic [7:0] t;
`ifdef JOY_CENTER_DEADZONE_EN
    int v;
    v = int'($signed(raw));
    if (v >= -DEADZONE && v <= DEADZONE) begin
      t = CENTER;
    end else begin
      t = raw ^ 8'h80;
    end
`else
    t = raw ^ 8'h80;
`endif
    return t;
  endfunction

  // pos is right/down, neg is left/up; both or neither park the pot at centre.
  function automatic logic [7:0] digital_target(input logic pos, input logic neg);
    logic [7:0] t;
    case ({pos, neg})
      2'b10:   t = 8'd255;
      2'b01:   t = 8'd0;
      default: t = CENTER;
    endcase
    return t;
  endfunction

  // Per-channel target, re-evaluated every cycle from the selected source.
  always_comb begin
    if (analog) begin
      tgt_s[0] = analog_target(joy_a1[7:0]);
      tgt_s[1] = analog_target(joy_a1[15:8]);
      tgt_s[2] = analog_target(joy_a2[7:0]);
      tgt_s[3] = analog_target(joy_a2[15:8]);
    end else begin
      tgt_s[0] = digital_target(dj1[0], dj1[1]);
      tgt_s[1] = digital_target(dj1[2], dj1[3]);
      tgt_s[2] = digital_target(dj2[0], dj2[1]);
      tgt_s[3] = digital_target(dj2[2], dj2[3]);
    end
  end

  // Free-running tick divider.
  always_comb begin
    tick_s = (cnt_q == TICK_LAST);
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Pass sequencer: one channel per state after each tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tick_s) begin
          state_d = S1;
        end else begin
          state_d = IDLE;
        end
      end
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = S4;
      S4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel selection for the shared slew path.
  always_comb begin
    sel_en_s  = 1'b1;
    sel_idx_s = 2'd0;
    case (state_q)
      S1:      sel_idx_s = 2'd0;
      S2:      sel_idx_s = 2'd1;
      S3:      sel_idx_s = 2'd2;
      S4:      sel_idx_s = 2'd3;
      default: sel_en_s  = 1'b0;
    endcase
  end

  // Shared slew path: step is clamped to the distance, so it cannot overshoot or wrap.
  always_comb begin
    sel_cur_s = ch_q[sel_idx_s];
    sel_tgt_s = tgt_s[sel_idx_s];
    up_s      = (sel_tgt_s > sel_cur_s);
    if (up_s) begin
      diff_s = sel_tgt_s - sel_cur_s;
    end else begin
      diff_s = sel_cur_s - sel_tgt_s;
    end
    if (diff_s < STEP_V) begin
      step_s = diff_s;
    end else begin
      step_s = STEP_V;
    end
    if (up_s) begin
      slewed_s = sel_cur_s + step_s;
    end else begin
      slewed_s = sel_cur_s - step_s;
    end
  end

  // Next channel values and the end-of-pass pulse.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_d[i] = ch_q[i];
    end
    if (sel_en_s) begin
      ch_d[sel_idx_s] = slewed_s;
    end else begin
      ch_d[0] = ch_q[0];
    end
    upd_d = (state_q == S4);
  end

  // State registers; reset overrides any tick or pass in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ch_q[i] <= CENTER;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      for (int i = 0; i < 4; i++) begin
        ch_q[i] <= ch_d[i];
      end
    end
  end

  assign ch1 = ch_q[0];
  assign ch2 = ch_q[1];
  assign ch3 = ch_q[2];
  assign ch4 = ch_q[3];
  assign upd = upd_q;

endmodule

// File: tb/tb_joy_pot_slew.sv
// Self-checking bench for joy_pot_slew: vector table, directed timing sequences and
// randomized stimulus against a cycle-count based reference model.
module tb_joy_pot_slew;

  localparam int TICK_DIV = 16;
  localparam int STEP     = 4;
  localparam int DEADZONE = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        analog = 1'b0;
  logic [15:0] joy_a1 = 16'h0000;
  logic [15:0] joy_a2 = 16'h0000;
  logic [3:0]  dj1 = 4'h0;
  logic [3:0]  dj2 = 4'h0;
  logic [7:0]  ch1, ch2, ch3, ch4;
  logic        upd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  joy_pot_slew #(.TICK_DIV(TICK_DIV), .STEP(STEP), .DEADZONE(DEADZONE)) dut (
    .clk(clk), .reset(reset), .analog(analog),
    .joy_a1(joy_a1), .joy_a2(joy_a2), .dj1(dj1), .dj2(dj2),
    .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4), .upd(upd)
  );

  // Reference: t counts cycles since reset; pass k starts after cycle 16k-1, so channel j
  // is slewed at the end of cycle t when t>=16 and t%16==j, and upd is high when t%16==4.
  int         m_t;
  logic [7:0] m_ch [4];
  logic       m_upd;

  function automatic int ref_target(int j);
    logic [15:0] a;
    logic [3:0]  d;
    byte         sb;
    int          v;
    bit          pos, neg;
    a = (j < 2) ? joy_a1 : joy_a2;
    d = (j < 2) ? dj1 : dj2;
    if (analog) begin
      sb = (j % 2 == 0) ? a[7:0] : a[15:8];
      v  = sb;
`ifdef JOY_CENTER_DEADZONE_EN
      if (v >= -DEADZONE && v <= DEADZONE) return 128;
`endif
      return v + 128;
    end
    pos = (j % 2 == 0) ? d[0] : d[2];
    neg = (j % 2 == 0) ? d[1] : d[3];
    if (pos && !neg) return 255;
    if (neg && !pos) return 0;
    return 128;
  endfunction

  function automatic logic [7:0] ref_slew(int cur, int tgt);
    int d;
    d = tgt - cur;
    if (d > STEP) d = STEP;
    if (d < -STEP) d = -STEP;
    return 8'(cur + d);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t   <= 0;
      m_upd <= 1'b0;
      for (int j = 0; j < 4; j++) m_ch[j] <= 8'd128;
    end else begin
      m_t   <= m_t + 1;
      m_upd <= (m_t + 1 >= TICK_DIV + 4) && ((m_t + 1) % TICK_DIV == 4);
      for (int j = 0; j < 4; j++) begin
        if (m_t >= TICK_DIV && (m_t % TICK_DIV) == j)
          m_ch[j] <= ref_slew(int'(m_ch[j]), ref_target(j));
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge clk);
    total++;
    if ({ch1, ch2, ch3, ch4, upd} !== {m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_upd}) begin
      bad++;
      $display("FAIL model t=%0d got ch=%0d,%0d,%0d,%0d upd=%0b want ch=%0d,%0d,%0d,%0d upd=%0b",
               m_t, ch1, ch2, ch3, ch4, upd, m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_upd);
    end
  endtask

  task automatic wait_upd();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!upd && n < 40);
    chk("upd_seen", int'(upd), 1);
  endtask

  task automatic set_inputs(logic an, logic [15:0] a1, logic [15:0] a2, logic [3:0] d1, logic [3:0] d2);
    analog = an; joy_a1 = a1; joy_a2 = a2; dj1 = d1; dj2 = d2;
  endtask

  // Two reset cycles; returns in cycle 0 of the new count with reset still high.
  task automatic hold_reset();
    reset = 1'b1;
    step();
    step();
  endtask

  task automatic check_center(string name);
    chk({name, "_ch1"}, int'(ch1), 128);
    chk({name, "_ch2"}, int'(ch2), 128);
    chk({name, "_ch3"}, int'(ch3), 128);
    chk({name, "_ch4"}, int'(ch4), 128);
    chk({name, "_upd"}, int'(upd), 0);
  endtask

  task automatic count_first_upd(string name);
    int n;
    n = 1;
    do begin
      step();
      n++;
    end while (!upd && n < 40);
    chk(name, n, 21);
  endtask

  typedef struct {
    logic        an;
    logic [15:0] a1, a2;
    logic [3:0]  d1, d2;
    int          e1, e2, e3, e4;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int e;
    int dz_lo;

    vecs[0] = '{1'b1, 16'h807F, 16'h0100, 4'h0, 4'h0, 255, 0, 128, 129};
    vecs[1] = '{1'b1, 16'hFFF8, 16'h0977, 4'h0, 4'h0, 120, 127, 247, 137};
    vecs[2] = '{1'b1, 16'h09F7, 16'h8000, 4'h0, 4'h0, 119, 137, 128, 0};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 4'b0001, 4'b1000, 255, 128, 128, 0};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 4'b0011, 4'b0110, 128, 128, 0, 255};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 4'b1100, 4'b1001, 128, 128, 255, 0};
    vecs[6] = '{1'b0, 16'h7F7F, 16'h8080, 4'h0, 4'h0, 128, 128, 128, 128};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 4'b1111, 4'b0101, 128, 128, 128, 128};
`ifdef JOY_CENTER_DEADZONE_EN
    vecs[0].e4 = 128;
    vecs[1].e1 = 128;
    vecs[1].e2 = 128;
`endif

    @(negedge clk);

    // Reset with random inputs, then time the first pass.
    set_inputs(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
    hold_reset();
    check_center("reset");
    reset = 1'b0;
    count_first_upd("first_upd_cycle");

    // Analog ramp on ch1 up to the rail.
    set_inputs(1'b1, 16'h007F, 16'h0000, 4'h0, 4'h0);
    hold_reset();
    reset = 1'b0;
    for (int p = 1; p <= 34; p++) begin
      wait_upd();
      e = (128 + 4 * p > 255) ? 255 : 128 + 4 * p;
      chk("ramp_ch1", int'(ch1), e);
    end
    chk("ramp_ch2", int'(ch2), 128);
    chk("ramp_ch3", int'(ch3), 128);
    chk("ramp_ch4", int'(ch4), 128);

    // Reset during S2 of the fourth pass.
    hold_reset();
    reset = 1'b0;
    for (int p = 0; p < 3; p++) wait_upd();
    for (int i = 0; i < 13; i++) step();
    chk("midramp_pre_ch1", int'(ch1), 144);
    reset = 1'b1;
    step();
    check_center("midramp_reset");
    reset = 1'b0;
    count_first_upd("midramp_restart_upd");
    chk("midramp_restart_ch1", int'(ch1), 132);

    // Digital left then both: 128 -> 0 -> 128.
    set_inputs(1'b0, 16'h0000, 16'h0000, 4'b0010, 4'b0000);
    hold_reset();
    reset = 1'b0;
    for (int p = 1; p <= 32; p++) begin
      wait_upd();
      e = (128 - 4 * p < 0) ? 0 : 128 - 4 * p;
      chk("dig_left_ch1", int'(ch1), e);
    end
    dj1 = 4'b0011;
    for (int p = 1; p <= 32; p++) begin
      wait_upd();
      e = (4 * p > 128) ? 128 : 4 * p;
      chk("dig_both_ch1", int'(ch1), e);
    end

    // Latency: tick in cycle 15, ch1 moves from cycle 17, ch4 from 20, upd only in 20.
    set_inputs(1'b0, 16'h0000, 16'h0000, 4'b0001, 4'b0100);
    hold_reset();
    reset = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c >= 15) begin
        chk("lat_ch1", int'(ch1), (c >= 17) ? 132 : 128);
        chk("lat_ch4", int'(ch4), (c >= 20) ? 132 : 128);
        chk("lat_upd", int'(upd), (c == 20) ? 1 : 0);
      end
    end

    // Small positive analog value near centre.
    set_inputs(1'b1, 16'h0005, 16'h0000, 4'h0, 4'h0);
    hold_reset();
    reset = 1'b0;
`ifdef JOY_CENTER_DEADZONE_EN
    dz_lo = 128;
`else
    dz_lo = 132;
`endif
    wait_upd();
    chk("deadband_pass1", int'(ch1), dz_lo);
    wait_upd();
`ifdef JOY_CENTER_DEADZONE_EN
    chk("deadband_pass2", int'(ch1), 128);
`else
    chk("deadband_pass2", int'(ch1), 133);
`endif

    // Vector table: hold each input set long enough to settle at the target.
    for (int v = 0; v < 8; v++) begin
      set_inputs(vecs[v].an, vecs[v].a1, vecs[v].a2, vecs[v].d1, vecs[v].d2);
      for (int p = 0; p < 70; p++) wait_upd();
      chk($sformatf("vec%0d_ch1", v), int'(ch1), vecs[v].e1);
      chk($sformatf("vec%0d_ch2", v), int'(ch2), vecs[v].e2);
      chk($sformatf("vec%0d_ch3", v), int'(ch3), vecs[v].e3);
      chk($sformatf("vec%0d_ch4", v), int'(ch4), vecs[v].e4);
    end

    // Randomized inputs and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: analog = 1'($urandom);
          1: joy_a1 = 16'($urandom);
          2: joy_a2 = 16'($urandom);
          3: dj1 = 4'($urandom);
          default: dj2 = 4'($urandom);
        endcase
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joy_pot_slew.md
Name: joy_pot_slew

Overview:
- Upstream feeder for the ADC0844 joystick converter model.
- Turns two MiSTer joysticks into four 8-bit "potentiometer" voltages ch1..ch4 that drive the converter channel inputs.
- Source is either the signed analog sticks or the 4-bit digital directions.
- Each output slews toward its target at a bounded rate, emulating real pot travel so Einstein software sees plausible intermediate readings.

Parameters:
- TICK_DIV, 1024: clk cycles per slew tick. Must be at least 8.
- STEP, 4: maximum change per channel per tick, in LSBs. Range 1..255.
- DEADZONE, 8: centre dead band half-width for signed analog input. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- analog  in  1  1 = targets from joy_a1/joy_a2; 0 = targets from dj1/dj2
- joy_a1  in  16  joystick 1 analog: [7:0] X signed, [15:8] Y signed
- joy_a2  in  16  joystick 2 analog, same format
- dj1  in  4  joystick 1 digital: [0] right, [1] left, [2] down, [3] up
- dj2  in  4  joystick 2 digital, same format
- ch1  out  8  joystick 1 X pot value
- ch2  out  8  joystick 1 Y pot value
- ch3  out  8  joystick 2 X pot value
- ch4  out  8  joystick 2 Y pot value
- upd  out  1  one-cycle pulse when a full 4-channel slew pass has completed

Behaviour:
- Reset (synchronous, active-high):
  - ch1..ch4 = 128, upd = 0.
  - Tick counter = 0, sequencer state = IDLE.
  - Reset wins over any tick or pass in progress.
- Target computation (combinational, re-evaluated every cycle):
  - analog=1: target = signed value XOR 0x80. So -128 → 0, 0 → 128, +127 → 255.
  - analog=0, X axis: right only → 255; left only → 0; neither or both → 128.
  - analog=0, Y axis: down only → 255; up only → 0; neither or both → 128.
  - Axis-to-channel map: ch1 = J1 X, ch2 = J1 Y, ch3 = J2 X, ch4 = J2 Y.
- Tick counter:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - The cycle in which it holds TICK_DIV-1 is the tick cycle.
  - It runs continuously and independently of the sequencer.
- Sequencer states: IDLE → S1 → S2 → S3 → S4 → IDLE, one state per cycle.
  - IDLE → S1 on the edge ending the tick cycle; otherwise it stays in IDLE.
  - In Sk, the edge ending that cycle updates ch_k from the target sampled in that cycle.
  - Only one shared compare/subtract path is used.
- Slew arithmetic, with d = |target - ch_k| computed as unsigned 8-bit:
  - target > ch_k: ch_k += min(STEP, d).
  - target < ch_k: ch_k -= min(STEP, d).
  - Equal: hold.
  - Never overshoots the target; never wraps past 0 or 255.
- upd:
  - Registered; high for exactly the one cycle after S4.
  - Tick cycle at N → ch1 changes after edge N+1, ch4 after edge N+4, upd high during cycle N+5.
  - upd pulses on every pass, even if no channel changed.
- A tick cannot occur during S1..S4 because TICK_DIV ≥ 8.
- Input changes mid-pass: channels not yet processed use the new target in the same pass. Mode switches follow the same rule and cause no output jump; outputs slew.

Optional Feature:
- Macro: JOY_CENTER_DEADZONE_EN.
- Defined: in analog mode, a signed axis value v with -DEADZONE ≤ v ≤ DEADZONE gives target 128. Values outside the band pass through unchanged (no rescaling).
- Undefined: no dead band; DEADZONE is ignored.
- Digital mode is unaffected either way.

Test Plan (TICK_DIV=16, STEP=4 unless noted):
- Reset: assert reset 2 cycles with random inputs → ch1..ch4 = 128, upd = 0; first upd exactly 21 cycles after reset deasserts.
- Analog ramp: analog=1, joy_a1[7:0]=0x7F → ch1 reads 132, 136, … 252 after 31 passes, 255 after pass 32, then stays 255; ch2..ch4 stay 128.
- Digital: analog=0, dj1=0010 → ch1 reaches 0 after 32 passes (128 → 0). Then dj1=0011 → ch1 returns to 128 after 32 passes.
- Latency: force tick at cycle N with target 255 → ch1 changes after edge N+1, ch4 (J2 Y down) after N+4, upd high only in cycle N+5.
- Reset mid-ramp: assert reset during S2 → next cycle all ch = 128, no upd; sequencer restarts from IDLE.
- Dead band: analog=1, X1=0x05 → with JOY_CENTER_DEADZONE_EN, ch1 stays 128; without it, ch1 = 132 then 133 after 2 passes.
